// File: rtl/arb_pkg.sv
// Shared types for the round-robin req/gnt arbiter, plus a rotating-priority
// reference function used by anything that needs a golden pick.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

  // One-hot of the first set bit of req searching ptr, ptr+1, ... mod n (n <= 16)
  function automatic logic [15:0] rr_onehot(input logic [15:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
    logic [15:0] oh;
    int unsigned j;
    oh = '0;
    for (int unsigned k = 0; k < n; k++) begin
      j = (ptr + k) % n;
      if (req[j] && oh == '0) oh[j] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: rotate by ptr, take the lowest set
// bit, rotate the index back.
module rr_priority_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] pick,
  output logic          any
);

  logic [N-1:0] rot;
  int           j;
  int           idx;
  int           p;

  always_comb begin
    rot = '0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(ptr);
      if (j >= N) j = j - N;
      rot[i] = eligible[j];
    end
    idx = 0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) idx = i;
    p = idx + int'(ptr);
    if (p >= N) p = p - N;
    pick = PW'(p);
    any  = |eligible;
  end

endmodule

// File: rtl/req_gnt_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grants, hold-until-release,
// a forced-revoke hold timeout and a mandatory one-cycle gap between owners.
module req_gnt_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N),
  localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id,
  output logic          timeout_pulse
);

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    nxt_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]     lock;
  logic [N-1:0]     eligible;
  logic             any;

  assign eligible = req & ~lock;
  assign nxt_ptr  = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);

  rr_priority_pick #(.N(N)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .pick     (pick),
    .any      (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      lock          <= '0;
      gnt           <= '0;
      gnt_valid     <= 1'b0;
      gnt_id        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      // A requester earns its way back from a timeout by dropping req once
      lock <= lock & req;
      case (state)
        IDLE: begin
          if (any) begin
            gnt       <= N'(1) << pick;
            gnt_valid <= 1'b1;
            gnt_id    <= pick;
            hold_cnt  <= CNT_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_id] || hold_cnt == CNT_W'(MAX_HOLD)) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= nxt_ptr;
            state     <= GAP;
            if (req[gnt_id]) begin
              timeout_pulse <= 1'b1;
              lock[gnt_id]  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt);
  a_pulse:  assert property (@(posedge clk) disable iff (!rst_n) timeout_pulse |=> !timeout_pulse);
  a_gap:    assert property (@(posedge clk) disable iff (!rst_n) $fell(gnt_valid) |=> !gnt_valid);

  for (genvar i = 0; i < N; i++) begin : g_lane
    a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n) gnt[i] |-> $past(req[i]));
  end

endmodule
